// File: rtl/reg_fifo_pkg.sv
// rtl/reg_fifo_pkg.sv - shared constants and helper functions for reg_fifo
package reg_fifo_pkg;

  // Reset value of every bit of the registered read word.
  localparam logic RDATA_RST_BIT = 1'b0;

  // Smallest r with 2**r >= n; used to size the entry index.
  function automatic int log2_ceil(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  // Pointers carry one extra wrap bit above the entry index so that
  // full and empty can be told apart when the indices match.
  function automatic int ptr_width(input int addr_w);
    return addr_w + 1;
  endfunction

endpackage

// File: rtl/fifo_ptr.sv
// rtl/fifo_ptr.sv - wrapping pointer register with increment enable
//
// Ports:
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset, clears ptr to 0
//   inc   - advance the pointer by one on the next rising edge
//   ptr   - current pointer value, rolls over modulo 2**W
module fifo_ptr #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] ptr
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (inc) begin
      ptr <= ptr + 1'b1;
    end
  end

endmodule

// File: rtl/reg_fifo.sv
// rtl/reg_fifo.sv - single-clock flop-based FIFO with full/empty and error pulses
//
// Ports:
//   Clk       - single clock, all state updates on the rising edge
//   Rn        - asynchronous active-low reset
//   WrEn      - write request
//   WrData    - write word, stored when the write is accepted
//   RdEn      - read request
//   RdData    - registered read word, valid one cycle after the accepting edge
//   Full      - no free entry
//   Empty     - no stored entry
//   Overflow  - one-cycle pulse after a rejected write
//   Underflow - one-cycle pulse after a rejected read
//   Level     - occupancy 0..DEPTH (only when REG_FIFO_LEVEL_EN is defined)
//
// Build option: define REG_FIFO_LEVEL_EN to add the Level output.
module reg_fifo
  import reg_fifo_pkg::*;
#(
  parameter  int WIDTH  = 8,
  parameter  int DEPTH  = 4,
  localparam int ADDR_W = log2_ceil(DEPTH),
  localparam int PTR_W  = ptr_width(ADDR_W)
) (
  input  logic             Clk,
  input  logic             Rn,
  input  logic             WrEn,
  input  logic [WIDTH-1:0] WrData,
  input  logic             RdEn,
  output logic [WIDTH-1:0] RdData,
  output logic             Full,
  output logic             Empty,
  output logic             Overflow,
  output logic             Underflow
`ifdef REG_FIFO_LEVEL_EN
  ,
  output logic [PTR_W-1:0] Level
`endif
);

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             wr_accept;
  logic             rd_accept;
  logic [WIDTH-1:0] mem [DEPTH];

  fifo_ptr #(.W(PTR_W)) u_wr_ptr (
    .clk   (Clk),
    .rst_n (Rn),
    .inc   (wr_accept),
    .ptr   (wr_ptr)
  );

  fifo_ptr #(.W(PTR_W)) u_rd_ptr (
    .clk   (Clk),
    .rst_n (Rn),
    .inc   (rd_accept),
    .ptr   (rd_ptr)
  );

  assign Empty = (wr_ptr == rd_ptr);
  assign Full  = (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]) &&
                 (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]);

  // A full FIFO still takes a write when a read frees a slot on the same
  // edge; an empty FIFO never bypasses write data to the read port.
  assign rd_accept = RdEn && !Empty;
  assign wr_accept = WrEn && (!Full || rd_accept);

  // Storage cells are deliberately left out of reset.
  always_ff @(posedge Clk) begin
    if (wr_accept) begin
      mem[wr_ptr[ADDR_W-1:0]] <= WrData;
    end
  end

  always_ff @(posedge Clk or negedge Rn) begin
    if (!Rn) begin
      RdData    <= {WIDTH{RDATA_RST_BIT}};
      Overflow  <= 1'b0;
      Underflow <= 1'b0;
    end else begin
      if (rd_accept) begin
        RdData <= mem[rd_ptr[ADDR_W-1:0]];
      end
      Overflow  <= WrEn && !wr_accept;
      Underflow <= RdEn && !rd_accept;
    end
  end

`ifdef REG_FIFO_LEVEL_EN
  // Modulo subtraction of the wrapped pointers yields 0..DEPTH directly.
  assign Level = wr_ptr - rd_ptr;
`endif

endmodule

// File: tb/tb_reg_fifo.sv
// tb/tb_reg_fifo.sv - directed self-checking bench for reg_fifo (WIDTH=8, DEPTH=4)
module tb_reg_fifo;

  logic       clk;
  logic       rn;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       rd_en;
  logic [7:0] rd_data;
  logic       full;
  logic       empty;
  logic       overflow;
  logic       underflow;
`ifdef REG_FIFO_LEVEL_EN
  logic [2:0] level;
`endif

  int errors;
  int checks;

  reg_fifo #(.WIDTH(8), .DEPTH(4)) dut (
    .Clk       (clk),
    .Rn        (rn),
    .WrEn      (wr_en),
    .WrData    (wr_data),
    .RdEn      (rd_en),
    .RdData    (rd_data),
    .Full      (full),
    .Empty     (empty),
    .Overflow  (overflow),
    .Underflow (underflow)
`ifdef REG_FIFO_LEVEL_EN
    ,
    .Level     (level)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [7:0] d);
    wr_en = 1'b1; wr_data = d; rd_en = 1'b0;
    step();
    wr_en = 1'b0;
  endtask

  task automatic test_reset();
    // Reset asserted from time 0 with a write request pending.
    #2;
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b expected 1", empty); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b expected 0", full); end
    checks++; if (rd_data !== 8'h00) begin errors++; $display("FAIL reset_rddata: got %h expected 00", rd_data); end
    checks++; if ({overflow, underflow} !== 2'b00) begin errors++; $display("FAIL reset_pulses: got %b expected 00", {overflow, underflow}); end
    step();
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_hold_empty: got %b expected 1", empty); end
    rn = 1'b1; wr_en = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_write(8'h5A);
    do_write(8'h6B);
    rd_en = 1'b1; step(); rd_en = 1'b0;
    checks++; if (rd_data !== 8'h5A) begin errors++; $display("FAIL mid_pre_read: got %h expected 5a", rd_data); end
    // Assert reset between edges; outputs must clear without a clock.
    #3;
    rn = 1'b0; wr_en = 1'b1; wr_data = 8'hEE;
    #1;
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL mid_empty: got %b expected 1", empty); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL mid_full: got %b expected 0", full); end
    checks++; if (rd_data !== 8'h00) begin errors++; $display("FAIL mid_rddata: got %h expected 00", rd_data); end
    checks++; if ({overflow, underflow} !== 2'b00) begin errors++; $display("FAIL mid_pulses: got %b expected 00", {overflow, underflow}); end
    step();
    rn = 1'b1; wr_en = 1'b0;
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL mid_after_release: got %b expected 1", empty); end
    do_write(8'h77);
    rd_en = 1'b1; step(); rd_en = 1'b0;
    checks++; if (rd_data !== 8'h77) begin errors++; $display("FAIL mid_first_write: got %h expected 77", rd_data); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL mid_drained: got %b expected 1", empty); end
  endtask

  task automatic test_fill_drain();
    logic [7:0] exp_q [4];
    exp_q = '{8'h11, 8'h22, 8'h33, 8'h44};
    for (int i = 0; i < 4; i++) begin
      do_write(exp_q[i]);
      checks++;
      if (full !== (i == 3)) begin errors++; $display("FAIL fill_full[%0d]: got %b expected %b", i, full, (i == 3)); end
    end
    checks++; if (empty !== 1'b0) begin errors++; $display("FAIL fill_empty: got %b expected 0", empty); end
    for (int i = 0; i < 4; i++) begin
      rd_en = 1'b1; step(); rd_en = 1'b0;
      checks++;
      if (rd_data !== exp_q[i]) begin errors++; $display("FAIL drain_data[%0d]: got %h expected %h", i, rd_data, exp_q[i]); end
      checks++;
      if (full !== 1'b0) begin errors++; $display("FAIL drain_full[%0d]: got %b expected 0", i, full); end
    end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL drain_empty: got %b expected 1", empty); end
  endtask

  task automatic test_overflow();
    logic [7:0] exp_q [4];
    exp_q = '{8'h11, 8'h22, 8'h33, 8'h44};
    for (int i = 0; i < 4; i++) do_write(exp_q[i]);
    wr_en = 1'b1; wr_data = 8'h55; step(); wr_en = 1'b0;
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_pulse: got %b expected 1", overflow); end
    checks++; if (full !== 1'b1) begin errors++; $display("FAIL ovf_full: got %b expected 1", full); end
    step();
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear: got %b expected 0", overflow); end
    for (int i = 0; i < 4; i++) begin
      rd_en = 1'b1; step(); rd_en = 1'b0;
      checks++;
      if (rd_data !== exp_q[i]) begin errors++; $display("FAIL ovf_data[%0d]: got %h expected %h", i, rd_data, exp_q[i]); end
    end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL ovf_empty: got %b expected 1", empty); end
  endtask

  task automatic test_underflow();
    wr_en = 1'b1; wr_data = 8'hA5; rd_en = 1'b1;
    step();
    wr_en = 1'b0; rd_en = 1'b0;
    checks++; if (underflow !== 1'b1) begin errors++; $display("FAIL unf_pulse: got %b expected 1", underflow); end
    checks++; if (rd_data !== 8'h44) begin errors++; $display("FAIL unf_rddata_hold: got %h expected 44", rd_data); end
    checks++; if (empty !== 1'b0) begin errors++; $display("FAIL unf_empty: got %b expected 0", empty); end
    step();
    checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL unf_clear: got %b expected 0", underflow); end
    rd_en = 1'b1; step(); rd_en = 1'b0;
    checks++; if (rd_data !== 8'hA5) begin errors++; $display("FAIL unf_read: got %h expected a5", rd_data); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL unf_drained: got %b expected 1", empty); end
  endtask

  task automatic test_full_wrap();
    for (int i = 0; i < 4; i++) do_write(8'(i + 1));
    for (int i = 0; i < 10; i++) begin
      wr_en = 1'b1; rd_en = 1'b1; wr_data = 8'(i + 5);
      step();
      checks++;
      if (rd_data !== 8'(i + 1)) begin errors++; $display("FAIL wrap_data[%0d]: got %h expected %h", i, rd_data, 8'(i + 1)); end
      checks++;
      if ({full, overflow, underflow} !== 3'b100) begin errors++; $display("FAIL wrap_flags[%0d]: got %b expected 100", i, {full, overflow, underflow}); end
    end
    wr_en = 1'b0; rd_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      rd_en = 1'b1; step(); rd_en = 1'b0;
      checks++;
      if (rd_data !== 8'(i + 11)) begin errors++; $display("FAIL wrap_tail[%0d]: got %h expected %h", i, rd_data, 8'(i + 11)); end
    end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL wrap_empty: got %b expected 1", empty); end
  endtask

`ifdef REG_FIFO_LEVEL_EN
  task automatic test_level();
    checks++; if (level !== 3'd0) begin errors++; $display("FAIL level_zero: got %0d expected 0", level); end
    for (int i = 0; i < 3; i++) do_write(8'(8'h30 + i));
    rd_en = 1'b1; step(); rd_en = 1'b0;
    checks++; if (level !== 3'd2) begin errors++; $display("FAIL level_two: got %0d expected 2", level); end
    do_write(8'h40);
    do_write(8'h41);
    checks++; if (level !== 3'd4) begin errors++; $display("FAIL level_four: got %0d expected 4", level); end
    checks++; if (full !== 1'b1) begin errors++; $display("FAIL level_full: got %b expected 1", full); end
  endtask
`endif

  initial begin
    errors = 0; checks = 0;
    rn = 1'b0; wr_en = 1'b1; wr_data = 8'hC3; rd_en = 1'b0;
    test_reset();
    test_reset_mid();
    test_fill_drain();
    test_overflow();
    test_underflow();
    test_full_wrap();
`ifdef REG_FIFO_LEVEL_EN
    test_level();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/reg_fifo.md
Name: reg_fifo

Overview:
Synchronous first-in first-out buffer built on edge-triggered storage. It sits directly downstream of the single-bit flip-flop stage, using banks of those flops as its storage cells.
It decouples a producer and a consumer that share one clock, with full/empty status and error pulses.
Intended as the first multi-word buffering primitive in the Memory library.

Parameters:
WIDTH, 8, data word width in bits (>=1)
DEPTH, 4, number of entries; power of two, >=2
ADDR_W, log2(DEPTH), derived pointer index width; do not override

Ports:
Clk  input  1  single clock; all state updates on rising edge
Rn  input  1  asynchronous active-low reset
WrEn  input  1  write request
WrData  input  WIDTH  write word, sampled when WrEn=1 and write accepted
RdEn  input  1  read request
RdData  output  WIDTH  registered read word
Full  output  1  no free entry
Empty  output  1  no stored entry
Overflow  output  1  one-cycle pulse: write rejected
Underflow  output  1  one-cycle pulse: read rejected

Behaviour:
- One clock Clk; reset Rn is asynchronous, active-low: asserting Rn=0 immediately clears state regardless of Clk.
- Reset values: write/read pointers=0, Empty=1, Full=0, RdData=0, Overflow=0, Underflow=0. Storage array not reset; contents don't-care.
- Pointers are ADDR_W+1 bits (extra wrap bit). Empty when pointers equal; Full when index bits equal and wrap bits differ. Full/Empty are combinational from registered pointers, so they change the cycle after the causing edge.
- Write accept: WrEn=1 and (Full=0 or read accepted same edge). On accept, store WrData at wr index, increment wr pointer (modulo 2*DEPTH).
- Read accept: RdEn=1 and Empty=0. On accept, RdData <= entry at rd index, increment rd pointer. Latency: data valid in RdData one cycle after the accepting edge. RdData holds its value when no read is accepted.
- Simultaneous read+write, not empty, not full: both accepted; occupancy unchanged.
- Simultaneous read+write when Full: both accepted, Full stays 1, no Overflow.
- Simultaneous read+write when Empty: write accepted, read rejected, Underflow pulses; no bypass of WrData to RdData.
- Overflow=1 for exactly the cycle after an edge with WrEn=1 and write rejected; Underflow likewise for a rejected read. Neither is sticky.
- Wrap-around: pointers roll from 2*DEPTH-1 to 0 with no gap in ordering.
- Reset mid-operation: all in-flight data discarded; after Rn release, FIFO is empty and the first write lands at index 0.

Optional Feature:
Macro REG_FIFO_LEVEL_EN.
- Defined: extra output Level, ADDR_W+1 bits, = wr pointer - rd pointer (modulo 2*DEPTH), range 0..DEPTH, reset 0, updates with the pointers.
- Not defined: no Level port and no subtractor logic; all other behaviour identical.

Decomposition:
- Shared package/include (reg_fifo_pkg): log2 constant function for ADDR_W, the pointer-width rule (ADDR_W+1), and the reset value constant for RdData.
- One sub-module, fifo_ptr: ADDR_W+1-bit pointer register with increment enable and async active-low reset.
- Instantiate fifo_ptr twice (write and read pointers). Full/Empty compare, storage array and read register stay in reg_fifo.

Test Plan:
- Reset: drive Rn=0 mid-clock with WrEn=1 -> Empty=1, Full=0, RdData=0, Overflow=Underflow=0 immediately, without waiting for a clock edge.
- Fill/drain, WIDTH=8, DEPTH=4: write 0x11,0x22,0x33,0x44 -> Full=1 after 4th edge. Read 4 times -> RdData 0x11,0x22,0x33,0x44 each one cycle after its read edge, Empty=1 after the last.
- Overflow: when Full, WrEn=1 with 0x55, RdEn=0 -> Overflow pulses 1 cycle, contents unchanged, the next 4 reads return 0x11..0x44.
- Underflow/empty simultaneous: when Empty, WrEn=1 with 0xA5 and RdEn=1 -> Underflow pulses, RdData unchanged, Empty=0. The next read returns 0xA5.
- Full simultaneous plus wrap: run 10 cycles of WrEn=RdEn=1 on a full FIFO with incrementing data -> Full stays 1, no error pulses, outputs in strict order across pointer wrap.
- REG_FIFO_LEVEL_EN defined: write 3, read 1 -> Level=2. Write 2 more with no reads -> Level=4 and Full=1.
